exec_memseq: RTL and testbench

Parametrised memory-access sequencer for the execute stage. It turns one microcode memory operation (read or write, byte or word, memory or I/O space) into one or two bus cycles on a strobe/ack bus. Word accesses at misaligned addresses are split into two cycles. It gives the execute stage a stall (`op_block`) and a read result, and generalises the single-cycle `mem_rdy` stall to wider data paths with real bus handshaking.

---
 rtl/exec_memseq.sv | 172 +++++++++++++++++
 tb/tb_exec_memseq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_memseq.sv
// Execute-stage memory sequencer: one microcode memory op becomes one or two strobe/ack bus cycles.
// Optional bus timeout abort is enabled by defining ZET_MEM_TIMEOUT_EN.
module exec_memseq #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic                  op_we,
  input  logic                  op_byte,
  input  logic                  op_mio,
  input  logic [ADDR_W-1:0]     op_addr,
  input  logic [DATA_W-1:0]     op_wdata,
  output logic                  op_block,
  output logic                  op_done,
  output logic [DATA_W-1:0]     op_rdata,
  output logic                  op_err,
  output logic                  bus_stb,
  output logic                  bus_we,
  output logic                  bus_mio,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_sel,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int L     = DATA_W / 8;
  localparam int OFF_W = $clog2(L);

  typedef enum logic [1:0] {S_IDLE, S_CYC1, S_CYC2, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_we, r_byte;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rd_lo;

  logic [OFF_W-1:0]    w_off, w_in_off;
  logic                w_split, w_ack, w_timeout;
  logic [ADDR_W-1:0]   w_base;
  logic [DATA_W-1:0]   w_rd_lo, w_rd_hi, w_rd_byte;

  // Lane enables: first cycle covers lanes off..L-1, second cycle lanes 0..off-1.
  function automatic logic [L-1:0] f_sel(input logic is_byte, input logic [OFF_W-1:0] off,
                                         input logic second);
    if (is_byte)     return L'(1) << off;
    else if (second) return {L{1'b1}} >> (L - int'(off));
    else             return {L{1'b1}} << off;
  endfunction

  function automatic logic [DATA_W-1:0] f_wdata(input logic is_byte, input logic [OFF_W-1:0] off,
                                                input logic second, input logic [DATA_W-1:0] data);
    if (is_byte)     return {L{data[7:0]}};
    else if (second) return data >> (8 * (L - int'(off)));
    else             return data << (8 * int'(off));
  endfunction

  assign w_off     = r_addr[OFF_W-1:0];
  assign w_in_off  = op_addr[OFF_W-1:0];
  assign w_split   = ~r_byte & (w_off != '0);
  assign w_base    = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_ack     = bus_stb & bus_ack;
  assign w_rd_lo   = bus_rdata >> (8 * int'(w_off));
  assign w_rd_hi   = bus_rdata << (8 * (L - int'(w_off)));
  assign w_rd_byte = {{(DATA_W-8){1'b0}}, w_rd_lo[7:0]};

  assign op_block  = op_valid & (r_state != S_DONE);
  assign op_done   = (r_state == S_DONE);

`ifdef ZET_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = bus_stb & ~bus_ack & (r_cnt == CNT_W'(TIMEOUT - 1));
  assign op_err    = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && op_valid) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_CYC1 && w_next == S_CYC2) begin
      r_cnt <= '0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (bus_stb && !bus_ack) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
  assign op_err    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (op_valid) w_next = S_CYC1;
      S_CYC1: if (w_timeout)  w_next = S_DONE;
              else if (w_ack) w_next = w_split ? S_CYC2 : S_DONE;
      S_CYC2: if (w_timeout || w_ack) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_byte    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_lo   <= '0;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_mio   <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      op_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (op_valid) begin
          r_we      <= op_we;
          r_byte    <= op_byte;
          r_addr    <= op_addr;
          r_wdata   <= op_wdata;
          bus_stb   <= 1'b1;
          bus_we    <= op_we;
          bus_mio   <= op_mio;
          bus_addr  <= {op_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          bus_sel   <= f_sel(op_byte, w_in_off, 1'b0);
          bus_wdata <= f_wdata(op_byte, w_in_off, 1'b0, op_wdata);
        end
        S_CYC1: if (w_timeout) begin
          bus_stb  <= 1'b0;
          op_rdata <= '1;
        end else if (w_ack) begin
          bus_stb <= 1'b0;
          if (w_split)    r_rd_lo  <= w_rd_lo;
          else if (!r_we) op_rdata <= r_byte ? w_rd_byte : bus_rdata;
        end
        S_CYC2: if (!bus_stb) begin
          // Idle cycle after the first ack, then launch the upper-address half.
          bus_stb   <= 1'b1;
          bus_addr  <= w_base + ADDR_W'(L);
          bus_sel   <= f_sel(r_byte, w_off, 1'b1);
          bus_wdata <= f_wdata(r_byte, w_off, 1'b1, r_wdata);
        end else if (w_timeout) begin
          bus_stb  <= 1'b0;
          op_rdata <= '1;
        end else if (w_ack) begin
          bus_stb <= 1'b0;
          if (!r_we) op_rdata <= r_rd_lo | w_rd_hi;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_memseq.sv
// Directed self-checking bench for exec_memseq (DATA_W=16, ADDR_W=20, TIMEOUT=16).
// Covers aligned, split, wrapping, byte and I/O accesses, reset abort and missing-ack behaviour.
module tb_exec_memseq;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_we, op_byte, op_mio;
  logic [19:0] op_addr;
  logic [15:0] op_wdata;
  logic        op_block, op_done, op_err;
  logic [15:0] op_rdata;
  logic        bus_stb, bus_we, bus_mio;
  logic [19:0] bus_addr;
  logic [1:0]  bus_sel;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  exec_memseq #(.DATA_W(16), .ADDR_W(20), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_we(op_we), .op_byte(op_byte), .op_mio(op_mio),
    .op_addr(op_addr), .op_wdata(op_wdata),
    .op_block(op_block), .op_done(op_done), .op_rdata(op_rdata), .op_err(op_err),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_mio(bus_mio), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic we, input logic byt, input logic mio,
                          input logic [19:0] addr, input logic [15:0] wdata);
    op_valid = 1'b1;
    op_we    = we;
    op_byte  = byt;
    op_mio   = mio;
    op_addr  = addr;
    op_wdata = wdata;
  endtask

  initial begin
    int  n_stb;
    bit  seen_done;
    bit  stb_dropped;

    rst = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_byte = 1'b0; op_mio = 1'b1;
    op_addr = '0; op_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_stb",   bus_stb,   0);
    check("rst_we",    bus_we,    0);
    check("rst_mio",   bus_mio,   0);
    check("rst_addr",  bus_addr,  0);
    check("rst_sel",   bus_sel,   0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rdata", op_rdata,  0);
    check("rst_done",  op_done,   0);
    check("rst_err",   op_err,    0);
    check("rst_block", op_block,  0);

    // Aligned word read with two wait cycles
    start_op(1'b0, 1'b0, 1'b1, 20'h01234, 16'h0000);
    #1 check("t1_block_idle", op_block, 1);
    step();
    check("t1_stb",  bus_stb,  1);
    check("t1_addr", bus_addr, 20'h01234);
    check("t1_sel",  bus_sel,  2'b11);
    check("t1_we",   bus_we,   0);
    check("t1_mio",  bus_mio,  1);
    op_addr = 20'h0FFFF;
    step();
    check("t1_wait1_stb", bus_stb, 1);
    step();
    check("t1_wait2_stb",   bus_stb,  1);
    check("t1_wait2_block", op_block, 1);
    check("t1_addr_held",   bus_addr, 20'h01234);
    bus_ack = 1'b1; bus_rdata = 16'hBEEF;
    step();
    bus_ack = 1'b0; bus_rdata = 16'h0000;
    check("t1_done",      op_done,  1);
    check("t1_rdata",     op_rdata, 16'hBEEF);
    check("t1_block_low", op_block, 0);
    check("t1_stb_low",   bus_stb,  0);
    op_valid = 1'b0;
    step();
    check("t1_done_pulse", op_done,  0);
    check("t1_rdata_hold", op_rdata, 16'hBEEF);

    // Misaligned word write split into two cycles
    start_op(1'b1, 1'b0, 1'b1, 20'h01235, 16'hA1B2);
    step();
    check("t2_c1_stb",   bus_stb,         1);
    check("t2_c1_addr",  bus_addr,        20'h01234);
    check("t2_c1_sel",   bus_sel,         2'b10);
    check("t2_c1_wdata", bus_wdata[15:8], 8'hB2);
    check("t2_c1_we",    bus_we,          1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("t2_gap_stb",  bus_stb, 0);
    check("t2_gap_done", op_done, 0);
    step();
    check("t2_c2_stb",   bus_stb,        1);
    check("t2_c2_addr",  bus_addr,       20'h01236);
    check("t2_c2_sel",   bus_sel,        2'b01);
    check("t2_c2_wdata", bus_wdata[7:0], 8'hA1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("t2_done",       op_done,  1);
    check("t2_rdata_hold", op_rdata, 16'hBEEF);
    op_valid = 1'b0;
    step();

    // Split read wrapping past the top of the address space
    start_op(1'b0, 1'b0, 1'b1, 20'hFFFFF, 16'h0000);
    step();
    check("t3_c1_addr", bus_addr, 20'hFFFFE);
    check("t3_c1_sel",  bus_sel,  2'b10);
    bus_ack = 1'b1; bus_rdata = 16'h5500;
    step();
    bus_ack = 1'b0; bus_rdata = 16'h0000;
    step();
    check("t3_c2_stb",  bus_stb,  1);
    check("t3_c2_addr", bus_addr, 20'h00000);
    check("t3_c2_sel",  bus_sel,  2'b01);
    bus_ack = 1'b1; bus_rdata = 16'h0066;
    step();
    bus_ack = 1'b0; bus_rdata = 16'h0000;
    check("t3_done",  op_done,  1);
    check("t3_rdata", op_rdata, 16'h6655);
    op_valid = 1'b0;
    step();

    // Byte I/O read, zero-wait ack (minimum latency)
    start_op(1'b0, 1'b1, 1'b0, 20'h00101, 16'h0000);
    step();
    check("t4_sel",  bus_sel,  2'b10);
    check("t4_mio",  bus_mio,  0);
    check("t4_addr", bus_addr, 20'h00100);
    bus_ack = 1'b1; bus_rdata = 16'h7A00;
    step();
    bus_ack = 1'b0; bus_rdata = 16'h0000;
    check("t4_done",  op_done,  1);
    check("t4_rdata", op_rdata, 16'h007A);
    op_valid = 1'b0;
    step();

    // Byte write to the odd lane
    start_op(1'b1, 1'b1, 1'b1, 20'h00103, 16'h345C);
    step();
    check("tb_sel",   bus_sel,         2'b10);
    check("tb_wdata", bus_wdata[15:8], 8'h5C);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("tb_done", op_done, 1);
    op_valid = 1'b0;
    step();

    // Reset during the second cycle of a split write
    start_op(1'b1, 1'b0, 1'b1, 20'h01235, 16'hA1B2);
    step();
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    check("t5_c2_stb", bus_stb, 1);
    rst = 1'b1; op_valid = 1'b0; bus_ack = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_stb",  bus_stb, 0);
    check("t5_rst_done", op_done, 0);
    step();
    bus_ack = 1'b0;
    check("t5_late_ack_done",  op_done,  0);
    check("t5_late_ack_stb",   bus_stb,  0);
    check("t5_late_ack_block", op_block, 0);
    start_op(1'b1, 1'b0, 1'b1, 20'h00010, 16'h1234);
    step();
    check("t5_new_sel",   bus_sel,   2'b11);
    check("t5_new_wdata", bus_wdata, 16'h1234);
    check("t5_new_addr",  bus_addr,  20'h00010);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("t5_new_done",  op_done,  1);
    check("t5_new_rdata", op_rdata, 16'h0000);
    op_valid = 1'b0;
    step();

    // Missing ack
    start_op(1'b0, 1'b0, 1'b1, 20'h00200, 16'h0000);
`ifdef ZET_MEM_TIMEOUT_EN
    n_stb = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (op_done) begin
        seen_done = 1'b1;
        break;
      end
      if (bus_stb) n_stb++;
    end
    check("t6_done_seen", seen_done, 1);
    check("t6_stb_cycles", n_stb,    16);
    check("t6_err",        op_err,   1);
    check("t6_rdata",      op_rdata, 16'hFFFF);
    check("t6_stb_low",    bus_stb,  0);
    op_valid = 1'b0;
    step();
    start_op(1'b0, 1'b0, 1'b1, 20'h00000, 16'h0000);
    step();
    check("t6_err_clear", op_err, 0);
    bus_ack = 1'b1; bus_rdata = 16'h0001;
    step();
    bus_ack = 1'b0; bus_rdata = 16'h0000;
    check("t6_after_rdata", op_rdata, 16'h0001);
    op_valid = 1'b0;
    step();
`else
    seen_done   = 1'b0;
    stb_dropped = 1'b0;
    step();
    for (int i = 0; i < 40; i++) begin
      if (op_done)  seen_done   = 1'b1;
      if (!bus_stb) stb_dropped = 1'b1;
      step();
    end
    check("t6_no_done",     seen_done,   0);
    check("t6_stb_held",    stb_dropped, 0);
    check("t6_block_held",  op_block,    1);
    check("t6_err_zero",    op_err,      0);
    rst = 1'b1; op_valid = 1'b0;
    step();
    rst = 1'b0;
    check("t6_rst_stb", bus_stb, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
